lfu_victim_select: RTL and testbench

//  Replacement-victim picker for the set-associative cache. It sits directly downstream of the LFU usage-counter array.
//  On a miss request for a set it scans that set's way counters through the counter array's read port.
//  It returns the way with the lowest use count. An invalid way is always preferred, with no scan.
//  The cache controller then refills that way and clears its counter.

---
 rtl/lfu_victim_select.sv | 112 +++++++++++
 tb/tb_lfu_victim_select.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lfu_victim_select.sv
// LFU replacement-victim picker: an invalid way wins at once, otherwise the set's
// usage counters are scanned and the lowest count wins, with ties going to the lowest way.
module lfu_victim_select #(
    parameter int bitsDirect  = 10,
    parameter int sizeCounter = 4,
    parameter int NUM_WAYS    = 4
) (
    input  logic                               clk,
    input  logic                               gen_reset,
    input  logic                               req,
    input  logic [bitsDirect-$clog2(NUM_WAYS)-1:0] req_set,
    input  logic [NUM_WAYS-1:0]                way_valid,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(NUM_WAYS)-1:0]        victim_way,
    output logic [sizeCounter-1:0]             victim_count,
    output logic                               cnt_read,
    output logic [bitsDirect-1:0]              cnt_adress,
    input  logic [sizeCounter-1:0]             cnt_data
);
    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam int SET_BITS = bitsDirect - WAY_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state;
    logic [SET_BITS-1:0]    set_q;
    logic [WAY_BITS-1:0]    way_ptr;
    logic [sizeCounter-1:0] best_cnt;
    logic [WAY_BITS-1:0]    best_way;

    logic                   inv_any;
    logic [WAY_BITS-1:0]    inv_way;
    logic                   cand_valid;
    logic [WAY_BITS-1:0]    cand_way;
    logic                   take;
    logic [sizeCounter-1:0] nxt_best_cnt;
    logic [WAY_BITS-1:0]    nxt_best_way;

    // Outputs decode straight from state so a reset drops them without waiting for a clock.
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign cnt_read   = (state == S_SCAN);
    assign cnt_adress = (state == S_SCAN) ? {set_q, way_ptr} : '0;

    always_comb begin
        inv_any = 1'b0;
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                inv_any = 1'b1;
                inv_way = WAY_BITS'(i);
            end
        end
    end

    // cnt_data always belongs to the way issued one cycle earlier; in DRAIN way_ptr has wrapped.
    always_comb begin
        cand_valid   = ((state == S_SCAN) && (way_ptr != '0)) || (state == S_DRAIN);
        cand_way     = way_ptr - 1'b1;
        take         = cand_valid && ((cand_way == '0) || (cnt_data < best_cnt));
        nxt_best_cnt = take ? cnt_data : best_cnt;
        nxt_best_way = take ? cand_way : best_way;
    end

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            state        <= S_IDLE;
            set_q        <= '0;
            way_ptr      <= '0;
            best_cnt     <= '0;
            best_way     <= '0;
            victim_way   <= '0;
            victim_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        set_q    <= req_set;
                        way_ptr  <= '0;
                        best_cnt <= '0;
                        best_way <= '0;
                        if (inv_any) begin
                            victim_way   <= inv_way;
                            victim_count <= '0;
                            state        <= S_DONE;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    best_cnt <= nxt_best_cnt;
                    best_way <= nxt_best_way;
                    way_ptr  <= way_ptr + 1'b1;
                    if (way_ptr == WAY_BITS'(NUM_WAYS - 1)) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    best_cnt     <= nxt_best_cnt;
                    best_way     <= nxt_best_way;
                    victim_way   <= nxt_best_way;
                    victim_count <= nxt_best_cnt;
                    state        <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfu_victim_select.sv
// Randomized bench for lfu_victim_select against an argmin reference model and a
// registered counter-array model that floats its output when no read was issued.
module tb_lfu_victim_select;
    logic       clk = 1'b0;
    logic       gen_reset;
    logic       req;
    logic [7:0] req_set;
    logic [3:0] way_valid;
    logic       busy, done, cnt_read;
    logic [1:0] victim_way;
    logic [3:0] victim_count;
    logic [9:0] cnt_adress;
    wire  [3:0] cnt_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] mem [0:1023];
    logic       rd_v;
    logic [3:0] rd_d;

    always #5 clk = ~clk;

    lfu_victim_select dut (
        .clk          (clk),
        .gen_reset    (gen_reset),
        .req          (req),
        .req_set      (req_set),
        .way_valid    (way_valid),
        .busy         (busy),
        .done         (done),
        .victim_way   (victim_way),
        .victim_count (victim_count),
        .cnt_read     (cnt_read),
        .cnt_adress   (cnt_adress),
        .cnt_data     (cnt_data)
    );

    // Counter array: registered read port, high-Z unless the previous cycle issued a read.
    always @(posedge clk) begin
        rd_v <= cnt_read;
        if (cnt_read) rd_d <= mem[cnt_adress];
    end
    assign cnt_data = (rd_v === 1'b1) ? rd_d : 4'bzzzz;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: first invalid way with count 0, else minimum count, earliest way on ties.
    task automatic ref_victim(input logic [7:0] s, input logic [3:0] v,
                              output logic [1:0] ew, output logic [3:0] ec);
        int best;
        best = -1;
        for (int w = 0; w < 4; w++) begin
            if (!v[w] && best < 0) best = w;
        end
        if (best >= 0) begin
            ew = 2'(best);
            ec = 4'd0;
        end else begin
            ew = 2'd0;
            ec = mem[{s, 2'd0}];
            for (int w = 1; w < 4; w++) begin
                if (int'(mem[{s, 2'(w)}]) < int'(ec)) begin
                    ew = 2'(w);
                    ec = mem[{s, 2'(w)}];
                end
            end
        end
    endtask

    task automatic load_set(input logic [7:0] s, input logic [3:0] c0, input logic [3:0] c1,
                            input logic [3:0] c2, input logic [3:0] c3);
        mem[{s, 2'd0}] = c0;
        mem[{s, 2'd1}] = c1;
        mem[{s, 2'd2}] = c2;
        mem[{s, 2'd3}] = c3;
    endtask

    task automatic run_req(input logic [7:0] s, input logic [3:0] v, input bit hold, input bit nowait);
        int         cyc;
        int         reads;
        bit         seen;
        logic [1:0] ew;
        logic [3:0] ec;
        logic [1:0] rw;
        ref_victim(s, v, ew, ec);
        if (!nowait) @(negedge clk);
        req       = 1'b1;
        req_set   = s;
        way_valid = v;
        cyc   = 0;
        reads = 0;
        seen  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!hold) req = 1'b0;
            check_val("busy_in_flight", busy, 1);
            if (cnt_read) begin
                rw = reads[1:0];
                check_val("cnt_adress", cnt_adress, {s, rw});
                reads++;
            end
            if (done) seen = 1;
        end
        check_val("done_seen", seen, 1);
        check_val("latency", cyc, (&v) ? 6 : 1);
        check_val("read_count", reads, (&v) ? 4 : 0);
        check_val("victim_way", victim_way, ew);
        check_val("victim_count", victim_count, ec);
        @(negedge clk);
        check_val("done_pulse", done, 0);
        check_val("idle_busy", busy, 0);
        check_val("victim_held", victim_way, ew);
    endtask

    initial begin
        logic [7:0] s;
        logic [3:0] v;
        gen_reset = 1'b1;
        req       = 1'b0;
        req_set   = '0;
        way_valid = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom_range(0, 15));
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cnt_read", cnt_read, 0);
        check_val("rst_cnt_adress", cnt_adress, 0);
        check_val("rst_victim_way", victim_way, 0);
        check_val("rst_victim_count", victim_count, 0);
        repeat (2) @(negedge clk);
        gen_reset = 1'b0;

        load_set(8'd5, 4'd5, 4'd2, 4'd7, 4'd3);
        run_req(8'd5, 4'hf, 0, 0);

        // Reset in the middle of a scan must abort with no done and no partial result.
        load_set(8'd9, 4'd1, 4'd9, 4'd0, 4'd4);
        @(negedge clk);
        req = 1'b1; req_set = 8'd9; way_valid = 4'hf;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 gen_reset = 1'b1;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_cnt_read", cnt_read, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_victim_way", victim_way, 0);
        check_val("midrst_victim_count", victim_count, 0);
        check_val("midrst_cnt_adress", cnt_adress, 0);
        @(negedge clk);
        gen_reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("postrst_done", done, 0);
            check_val("postrst_busy", busy, 0);
        end

        load_set(8'd3, 4'd3, 4'd3, 4'd1, 4'd1);
        run_req(8'd3, 4'hf, 0, 0);
        load_set(8'd200, 4'd15, 4'd15, 4'd15, 4'd15);
        run_req(8'd200, 4'hf, 0, 0);
        run_req(8'd77, 4'b1011, 0, 0);
        run_req(8'd78, 4'b0000, 0, 0);

        // req held high through a scan, then chained straight into the first IDLE cycle.
        load_set(8'd12, 4'd4, 4'd4, 4'd4, 4'd0);
        run_req(8'd12, 4'hf, 1, 0);
        load_set(8'd13, 4'd6, 4'd1, 4'd8, 4'd2);
        run_req(8'd13, 4'hf, 0, 1);

        for (int n = 0; n < 60; n++) begin
            s = 8'($urandom_range(0, 255));
            v = ($urandom_range(0, 9) < 7) ? 4'hf : 4'($urandom_range(0, 15));
            for (int w = 0; w < 4; w++) mem[{s, 2'(w)}] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) mem[{s, 2'($urandom_range(0, 3))}] = 4'd15;
            run_req(s, v, 0, ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
